// File: rtl/circuit_bist.sv
// ============================================================================
// circuit_bist : exhaustive self-test controller for the 3-in/2-out `circuit`
// block. Optional MISR response signature under CIRCUIT_BIST_MISR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module circuit_bist #(
    parameter logic [7:0] EXP_X         = 8'hE8,
    parameter logic [7:0] EXP_Y         = 8'h96,
    parameter int         SETTLE_CYCLES = 2        // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx
`ifdef CIRCUIT_BIST_MISR_EN
    ,
    output logic [7:0] signature
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] c_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [2:0] r_vec;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [2:0] r_fail_idx;

    logic       w_mismatch;
    logic [3:0] w_err_next;

    assign w_mismatch = (x != EXP_X[r_idx]) | (y != EXP_Y[r_idx]);
    assign w_err_next = r_err_cnt + {3'b000, w_mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_vec      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 4'd0;
            r_fail_idx <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err_cnt  <= 4'd0;
                        r_pass     <= 1'b0;
                        r_fail_idx <= 3'd0;
                        r_idx      <= 3'd0;
                        r_vec      <= 3'd0;
                        r_cnt      <= c_CNT_LOAD;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && (r_err_cnt == 4'd0)) begin
                        r_fail_idx <= r_idx;
                    end
                    // pass is resolved here so it lands together with done
                    if (r_idx == 3'd7) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                        r_vec   <= 3'd0;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_vec   <= r_idx + 3'd1;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CIRCUIT_BIST_MISR_EN
    logic [7:0] r_sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= 8'h00;
        end else if ((r_state == S_IDLE) && start) begin
            r_sig <= 8'h00;
        end else if (r_state == S_CAPTURE) begin
            r_sig <= {r_sig[6:0], r_sig[7] ^ r_sig[5] ^ r_sig[4] ^ r_sig[3]}
                     ^ {6'b000000, x, y};
        end
    end

    assign signature = r_sig;
`endif

    assign a        = r_vec[2];
    assign b        = r_vec[1];
    assign c        = r_vec[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_idx = r_fail_idx;

endmodule

`default_nettype wire

// File: tb/tb_circuit_bist.sv
// ============================================================================
// tb_circuit_bist : directed self-checking bench for circuit_bist, three
// instances with SETTLE_CYCLES = 2, 1 and 15 driving a behavioural full adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_circuit_bist;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    int         mode;

    wire  [2:0] abc_w  [3];
    wire  [2:0] x_v;
    wire  [2:0] y_v;
    wire  [2:0] busy_v;
    wire  [2:0] done_v;
    wire  [2:0] pass_v;
    wire  [3:0] err_w  [3];
    wire  [2:0] fidx_w [3];
`ifdef CIRCUIT_BIST_MISR_EN
    wire  [7:0] sig_w  [3];
`endif

    int total_checks;
    int fail_checks;
    int settle [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full-adder model: x = carry, y = sum, with optional injected faults.
    function automatic logic [1:0] model(input logic [2:0] v, input int m);
        logic xg;
        logic yg;
        xg = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        yg = ^v;
        if (m == 1) xg = 1'b0;
        if (m == 2 && v == 3'd5) yg = ~yg;
        if (m == 3 && v == 3'd6) yg = ~yg;
        return {xg, yg};
    endfunction

    function automatic logic [7:0] misr_ref(input int m);
        logic [7:0] s;
        logic [1:0] r;
        s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r = model(3'(i), m);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b000000, r};
        end
        return s;
    endfunction

    assign {x_v[0], y_v[0]} = model(abc_w[0], mode);
    assign {x_v[1], y_v[1]} = model(abc_w[1], 0);
    assign {x_v[2], y_v[2]} = model(abc_w[2], 0);

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        circuit_bist #(
            .SETTLE_CYCLES(S)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .a        (abc_w[g][2]),
            .b        (abc_w[g][1]),
            .c        (abc_w[g][0]),
            .x        (x_v[g]),
            .y        (y_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .pass     (pass_v[g]),
            .err_cnt  (err_w[g]),
            .fail_idx (fidx_w[g])
`ifdef CIRCUIT_BIST_MISR_EN
            ,
            .signature(sig_w[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            fail_checks++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start on one instance and watches it to done; returns at the done cycle.
    task automatic run(input int inst, output int done_cyc, output int busy_cnt,
                       output int seq_err);
        int s;
        s = settle[inst];
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        done_cyc = 0;
        busy_cnt = 0;
        seq_err  = 0;
        for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
            if (busy_v[inst]) begin
                busy_cnt++;
                if (abc_w[inst] != 3'((cyc - 1) / (s + 1))) seq_err++;
            end else if (abc_w[inst] != 3'd0) begin
                seq_err++;
            end
            if (done_v[inst]) done_cyc = cyc;
            else @(negedge clk);
        end
    endtask

    initial begin
        int dc;
        int bc;
        int se;
        int done_seen;
        total_checks = 0;
        fail_checks  = 0;
        settle[0] = 2;
        settle[1] = 1;
        settle[2] = 15;
        rst     = 1'b1;
        start_v = 3'b000;
        mode    = 0;
        repeat (3) @(negedge clk);

        chk("rst_abc",     32'(abc_w[0]),  0);
        chk("rst_busy",    32'(busy_v[0]), 0);
        chk("rst_done",    32'(done_v[0]), 0);
        chk("rst_pass",    32'(pass_v[0]), 0);
        chk("rst_err_cnt", 32'(err_w[0]),  0);
        chk("rst_fail_idx",32'(fidx_w[0]), 0);
`ifdef CIRCUIT_BIST_MISR_EN
        chk("rst_sig",     32'(sig_w[0]),  0);
`endif
        rst = 1'b0;

        // Good full adder, default settle
        run(0, dc, bc, se);
        chk("good_done_cyc", 32'(dc), 25);
        chk("good_busy_cnt", 32'(bc), 24);
        chk("good_abc_seq",  32'(se), 0);
        chk("good_pass",     32'(pass_v[0]), 1);
        chk("good_err_cnt",  32'(err_w[0]),  0);
        chk("good_fail_idx", 32'(fidx_w[0]), 0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("done_one_pulse",     32'(done_v[0]), 0);
        chk("start_in_done_ign",  32'(busy_v[0]), 0);
        chk("pass_held",          32'(pass_v[0]), 1);
`ifdef CIRCUIT_BIST_MISR_EN
        chk("misr_good", 32'(sig_w[0]), 32'(misr_ref(0)));
`endif

        // x stuck-at-0
        mode = 1;
        run(0, dc, bc, se);
        chk("sa0_done_cyc", 32'(dc), 25);
        chk("sa0_pass",     32'(pass_v[0]), 0);
        chk("sa0_err_cnt",  32'(err_w[0]),  4);
        chk("sa0_fail_idx", 32'(fidx_w[0]), 3);

        // y inverted on vector 5 only
        mode = 2;
        run(0, dc, bc, se);
        chk("y5_pass",     32'(pass_v[0]), 0);
        chk("y5_err_cnt",  32'(err_w[0]),  1);
        chk("y5_fail_idx", 32'(fidx_w[0]), 5);

        // Settle-time boundaries
        run(1, dc, bc, se);
        chk("s1_done_cyc", 32'(dc), 17);
        chk("s1_busy_cnt", 32'(bc), 16);
        chk("s1_abc_seq",  32'(se), 0);
        chk("s1_pass",     32'(pass_v[1]), 1);
        run(2, dc, bc, se);
        chk("s15_done_cyc", 32'(dc), 129);
        chk("s15_busy_cnt", 32'(bc), 128);
        chk("s15_abc_seq",  32'(se), 0);
        chk("s15_pass",     32'(pass_v[2]), 1);

        // Restart attempt mid-run, then async reset on vector 4
        mode = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int cyc = 2; cyc <= 13; cyc++) begin
            @(negedge clk);
            start_v[0] = (cyc == 4);
        end
        start_v[0] = 1'b0;
        chk("mid_abc",      32'(abc_w[0]),  4);
        chk("mid_busy",     32'(busy_v[0]), 1);
        chk("mid_err_cnt",  32'(err_w[0]),  1);
        chk("mid_fail_idx", 32'(fidx_w[0]), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_abc",      32'(abc_w[0]),  0);
        chk("arst_busy",     32'(busy_v[0]), 0);
        chk("arst_err_cnt",  32'(err_w[0]),  0);
        chk("arst_fail_idx", 32'(fidx_w[0]), 0);
        chk("arst_pass",     32'(pass_v[0]), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_v[0]) done_seen = 1;
        end
        chk("arst_no_done", 32'(done_seen), 0);
        rst  = 1'b0;
        mode = 0;
        run(0, dc, bc, se);
        chk("fresh_done_cyc", 32'(dc), 25);
        chk("fresh_pass",     32'(pass_v[0]), 1);

`ifdef CIRCUIT_BIST_MISR_EN
        // Single-bit fault on vector 6 must perturb the signature
        mode = 3;
        run(0, dc, bc, se);
        chk("misr_fault_diff", 32'(sig_w[0] != misr_ref(0)), 1);
        chk("misr_fault_ref",  32'(sig_w[0]), 32'(misr_ref(3)));
        chk("misr_fault_cnt",  32'(err_w[0]), 1);
`endif

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/circuit_bist.md
Name: circuit_bist

Overview:
- Synthesizable built-in self-test controller for the team's 3-input/2-output combinational `circuit` block.
- Exhaustively drives all 8 input vectors {a,b,c} into the DUT and waits a programmable settle time after each one.
- Samples the x/y responses and compares them against expected truth tables given as parameters.
- Reports pass/fail, an error count and the first failing vector. Sits beside the DUT in hardware, replacing the stimulus/monitor role the simulation bench plays.

Parameters:
- EXP_X, 8'hE8, expected x output; bit i is the expected x when {a,b,c}==i (default is full-adder carry).
- EXP_Y, 8'h96, expected y output; bit i is the expected y when {a,b,c}==i (default is full-adder sum).
- SETTLE_CYCLES, 2, cycles each vector is held before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a self-test; accepted only in IDLE.
- a  out  1  DUT input A (MSB of vector index).
- b  out  1  DUT input B.
- c  out  1  DUT input C (LSB of vector index).
- x  in  1  DUT output X.
- y  in  1  DUT output Y.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the run completes.
- pass  out  1  1 when the last run had zero mismatches; held until the next start.
- err_cnt  out  4  number of mismatching vectors in the last run (0..8).
- fail_idx  out  3  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (async): state=IDLE.
  - a,b,c,busy,done,pass,fail_idx = 0; err_cnt = 0.
  - Internal idx = 0; settle counter = 0.
- All outputs are registered. {a,b,c} always equals the registered idx while busy, and 3'b000 otherwise.
- IDLE, start=1:
  - Clear err_cnt, pass, fail_idx and idx.
  - Load cnt = SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - Drive vector idx; the state lasts exactly SETTLE_CYCLES cycles.
  - If cnt==0, go to CAPTURE; otherwise decrement cnt.
- CAPTURE (1 cycle):
  - mismatch = (x != EXP_X[idx]) | (y != EXP_Y[idx]).
  - On mismatch, err_cnt increments. If err_cnt was 0, fail_idx <= idx.
  - If idx==7: go to DONE.
  - Otherwise: idx <= idx+1, reload cnt, return to SETTLE.
  - idx never wraps during a run.
- DONE (1 cycle):
  - done=1 and busy=0.
  - pass <= (final err_cnt==0), registered so it is valid in the same cycle as done.
  - Next state is IDLE.
- Timing: start accepted at edge T0 → done high in cycle T0 + 8*(SETTLE_CYCLES+1) + 1. With defaults this is 25 cycles.
- busy is high for 8*(SETTLE_CYCLES+1) cycles.
- start while busy or in DONE: ignored, no restart.
- start held high: a new run begins on the first IDLE cycle.
- err_cnt cannot exceed 8, so no saturation logic is needed.
- Reset asserted mid-run: immediately returns to the reset values above. No done pulse; pass=0.
- x/y are only sampled in CAPTURE; their values in any other state are don't-care.

Optional Feature:
- Macro: CIRCUIT_BIST_MISR_EN.
- When defined:
  - Adds output port `signature [7:0]`, reset to 8'h00 and cleared on start.
  - On each CAPTURE: sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {6'b0, x, y}.
  - Holds its value after DONE until the next start.
- When undefined: the port and all MISR logic are absent. The remaining behaviour is identical.

Test Plan:
- Defaults, correct full-adder model on x/y, pulse start → busy for 24 cycles; done at cycle 25; pass=1, err_cnt=0, fail_idx=0.
- x stuck-at-0 model → pass=0, err_cnt=4 (vectors 3,5,6,7), fail_idx=3.
- y inverted for vector 5 only → pass=0, err_cnt=1, fail_idx=5.
- SETTLE_CYCLES=1 → each vector held 1 cycle; done at cycle 17. SETTLE_CYCLES=15 → done at cycle 129. Bench checks the {a,b,c} sequence 0..7 in order.
- start re-pulsed mid-run, then rst asserted on vector 4 → restart ignored; on reset, all outputs 0 asynchronously and no done pulse. A fresh start afterwards passes.
- With CIRCUIT_BIST_MISR_EN: signature equals the bench reference model of the same recurrence for the good DUT. A single-bit fault on vector 6 changes the signature.
